// File: rtl/bayer_demosaic_2x2.sv
// Bayer-to-RGB demosaicer using a 2x2 window built from one line buffer and two
// column registers. It emits one RGB pixel per accepted RAW pixel once the window is complete.
module bayer_demosaic_2x2 #(
  parameter int DATA_W = 12,
  parameter int LINE_W = 640,
  parameter int CNT_W  = 16
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [DATA_W-1:0] iData,
  input  logic              iDataValid,
  input  logic              iSOF,
  input  logic [1:0]        iPattern,
  input  logic              iBypass,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              oDataValid,
  output logic              oSOF,
  output logic              oEOL,
  output logic [CNT_W-1:0]  oX,
  output logic [CNT_W-1:0]  oY
);

  localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [CNT_W-1:0] LAST_X = CNT_W'(LINE_W - 1);
  localparam logic [CNT_W-1:0] MAX_Y  = '1;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  // Input side: arming, coordinate counters and per-frame latches
  logic             armed;
  logic [CNT_W-1:0] nextX, nextY;
  logic [1:0]       patL;
  logic             bypL;
  logic             accept;
  logic [CNT_W-1:0] curX, curY;

  assign accept = iDataValid && (armed || iSOF);
  assign curX   = iSOF ? '0 : nextX;
  assign curY   = iSOF ? '0 : nextY;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      armed <= 1'b0;
      nextX <= '0;
      nextY <= '0;
      patL  <= 2'b00;
      bypL  <= 1'b0;
    end else if (accept) begin
      armed <= 1'b1;
      if (iSOF) begin
        patL <= iPattern;
        bypL <= iBypass;
      end
      if (curX == LAST_X) begin
        nextX <= '0;
        nextY <= (curY == MAX_Y) ? MAX_Y : curY + ONE;
      end else begin
        nextX <= curX + ONE;
        nextY <= curY;
      end
    end
  end

  // Line buffer: read-before-write, so lineRd returns the previous row's sample at x
  logic [DATA_W-1:0] lineMem [LINE_W];
  logic [DATA_W-1:0] lineRd;

  always_ff @(posedge iCLK) begin
    if (accept) begin
      lineRd               <= lineMem[curX[AW-1:0]];
      lineMem[curX[AW-1:0]] <= iData;
    end
  end

  // Window stage: s1 holds the newest pixel, col* hold the (x-1) column
  logic              s1Valid;
  logic [CNT_W-1:0]  s1X, s1Y;
  logic [DATA_W-1:0] s1Cur, colCur, colPrev;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      s1Valid <= 1'b0;
      s1X     <= '0;
      s1Y     <= '0;
      s1Cur   <= '0;
      colCur  <= '0;
      colPrev <= '0;
    end else begin
      s1Valid <= accept;
      if (accept) begin
        s1X   <= curX;
        s1Y   <= curY;
        s1Cur <= iData;
      end
      if (s1Valid) begin
        colCur  <= s1Cur;
        colPrev <= lineRd;
      end
    end
  end

  // Colour selection; phase is the window position re-expressed relative to GRBG
  logic [DATA_W-1:0] tl, tr, bl, br;
  logic [DATA_W-1:0] selR, selB, selGa, selGb;
  logic [DATA_W:0]   gSum;
  logic [1:0]        phase;
  logic              winDone;

  assign tl      = colPrev;
  assign tr      = lineRd;
  assign bl      = colCur;
  assign br      = s1Cur;
  assign phase   = {s1Y[0] ^ patL[1], s1X[0] ^ patL[0]};
  assign winDone = s1Valid && (s1X != '0) && (s1Y != '0);

  always_comb begin
    selR  = bl;
    selB  = tr;
    selGa = tl;
    selGb = br;
    case (phase)
      2'b00: begin selR = bl; selB = tr; selGa = tl; selGb = br; end
      2'b01: begin selR = br; selB = tl; selGa = bl; selGb = tr; end
      2'b10: begin selR = tl; selB = br; selGa = bl; selGb = tr; end
      2'b11: begin selR = tr; selB = bl; selGa = tl; selGb = br; end
      default: ;
    endcase
  end

  assign gSum = {1'b0, selGa} + {1'b0, selGb};

  // Output register: data and coordinates hold while no window completes
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oRed       <= '0;
      oGreen     <= '0;
      oBlue      <= '0;
      oDataValid <= 1'b0;
      oSOF       <= 1'b0;
      oEOL       <= 1'b0;
      oX         <= '0;
      oY         <= '0;
    end else begin
      oDataValid <= winDone;
      oSOF       <= winDone && (s1X == ONE) && (s1Y == ONE);
      oEOL       <= winDone && (s1X == LAST_X);
      if (winDone) begin
        oRed   <= bypL ? br : selR;
        oGreen <= bypL ? br : gSum[DATA_W:1];
        oBlue  <= bypL ? br : selB;
        oX     <= s1X - ONE;
        oY     <= s1Y - ONE;
      end
    end
  end

endmodule

// File: tb/tb_bayer_demosaic_2x2.sv
// Scoreboard bench for bayer_demosaic_2x2 with a 4-pixel line and 12-bit samples.
module tb_bayer_demosaic_2x2;
  localparam int DATA_W = 12;
  localparam int LINE_W = 4;
  localparam int CNT_W  = 16;
  localparam int EW     = 32 + 3*DATA_W + 2*CNT_W + 2;

  logic              iCLK, iRST_n;
  logic [DATA_W-1:0] iData;
  logic              iDataValid, iSOF, iBypass;
  logic [1:0]        iPattern;
  logic [DATA_W-1:0] oRed, oGreen, oBlue;
  logic              oDataValid, oSOF, oEOL;
  logic [CNT_W-1:0]  oX, oY;

  bayer_demosaic_2x2 #(.DATA_W(DATA_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iData(iData), .iDataValid(iDataValid),
    .iSOF(iSOF), .iPattern(iPattern), .iBypass(iBypass),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oDataValid(oDataValid),
    .oSOF(oSOF), .oEOL(oEOL), .oX(oX), .oY(oY)
  );

  // Clock and cycle counter
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // Scene colours and expected outputs for non-bypass frames
  logic [DATA_W-1:0] rV, gaV, gbV, bV;
  logic [DATA_W-1:0] expR, expG, expB;

  // Reference state of the frame being sent
  logic              mArmed;
  int                mx, my;
  logic [1:0]        mPat;
  logic              mByp;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic logic [DATA_W-1:0] pix(input int r, input int c, input logic [1:0] p, input logic byp);
    logic [1:0] ph;
    if (byp) return DATA_W'(r * 16 + c + 7);
    ph = {r[0] ^ p[1], c[0] ^ p[0]};
    case (ph)
      2'b00:   return gaV;
      2'b01:   return rV;
      2'b10:   return bV;
      default: return gbV;
    endcase
  endfunction

  task automatic send(input logic [DATA_W-1:0] d, input logic sof);
    logic [CNT_W-1:0] ex, ey;
    @(negedge iCLK); #1;
    iData = d; iSOF = sof; iDataValid = 1'b1;
    if (sof) begin
      mArmed = 1'b1; mx = 0; my = 0; mPat = iPattern; mByp = iBypass;
    end else if (!mArmed) begin
      return;
    end else if (mx == LINE_W - 1) begin
      mx = 0;
      if (my != 65535) my++;
    end else begin
      mx++;
    end
    if (mx >= 1 && my >= 1) begin
      ex = CNT_W'(mx - 1);
      ey = CNT_W'(my - 1);
      exp_q.push_back({32'(cyc + 2),
                       mByp ? d : expR, mByp ? d : expG, mByp ? d : expB,
                       ex, ey, (mx == 1 && my == 1), (mx == LINE_W - 1)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iCLK); #1;
      iDataValid = 1'b0; iSOF = 1'b0;
    end
  endtask

  // Sends npix pixels in raster order; first carries iSOF
  task automatic frame(input int npix, input logic [1:0] p, input logic byp, input logic gaps,
                       input logic toggle);
    iPattern = p; iBypass = byp;
    for (int i = 0; i < npix; i++) begin
      if (toggle && i == LINE_W) begin
        iPattern = ~p; iBypass = ~byp;
      end
      send(pix(i / LINE_W, i % LINE_W, p, byp), i == 0);
      if (gaps && (i % 2 == 0)) idle(2);
    end
  endtask

  // Monitor: pops one expectation per presented output
  always @(negedge iCLK) begin
    logic [EW-1:0] e, got;
    if (iRST_n && oDataValid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got x=%0d y=%0d R=%0d G=%0d B=%0d expected no output",
                 oX, oY, oRed, oGreen, oBlue);
      end else begin
        e   = exp_q.pop_front();
        got = {32'(cyc), oRed, oGreen, oBlue, oX, oY, oSOF, oEOL};
        if (got !== e) begin
          errors++;
          $display("FAIL output: got cyc=%0d R=%0d G=%0d B=%0d x=%0d y=%0d sof=%0b eol=%0b expected cyc=%0d R=%0d G=%0d B=%0d x=%0d y=%0d sof=%0b eol=%0b",
                   cyc, oRed, oGreen, oBlue, oX, oY, oSOF, oEOL,
                   e[EW-1 -: 32], e[3*DATA_W+2*CNT_W+1 -: DATA_W], e[2*DATA_W+2*CNT_W+1 -: DATA_W],
                   e[DATA_W+2*CNT_W+1 -: DATA_W], e[2*CNT_W+1 -: CNT_W], e[CNT_W+1 -: CNT_W], e[1], e[0]);
        end
      end
    end else if (iRST_n && (oSOF || oEOL)) begin
      checks++;
      errors++;
      $display("FAIL flag_without_valid: got sof=%0b eol=%0b expected 0", oSOF, oEOL);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(oDataValid), 0);
    chk({tag, "_red"},   32'(oRed), 0);
    chk({tag, "_green"}, 32'(oGreen), 0);
    chk({tag, "_blue"},  32'(oBlue), 0);
    chk({tag, "_x"},     32'(oX), 0);
    chk({tag, "_flags"}, 32'({oSOF, oEOL}), 0);
  endtask

  initial begin
    iRST_n = 1'b0; iData = '0; iDataValid = 1'b0; iSOF = 1'b0; iPattern = 2'b00; iBypass = 1'b0;
    mArmed = 1'b0; mx = 0; my = 0; mPat = 2'b00; mByp = 1'b0;
    rV = 12'd100; gaV = 12'd200; gbV = 12'd202; bV = 12'd50;
    expR = 12'd100; expG = 12'd201; expB = 12'd50;
    #12;
    chk_zero("reset");
    @(negedge iCLK); #1; iRST_n = 1'b1;

    // Pixels before any iSOF are ignored
    for (int i = 0; i < 5; i++) send(DATA_W'(i + 900), 1'b0);
    idle(3);

    // Continuous 4x3 frames in every pattern
    for (int p = 0; p < 4; p++) begin
      frame(12, 2'(p), 1'b0, 1'b0, 1'b0);
      idle(3);
    end

    // Pattern/bypass inputs toggled mid-frame have no effect
    frame(12, 2'b01, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Saturated greens must not wrap
    rV = 12'd4095; gaV = 12'd4095; gbV = 12'd4095; bV = 12'd0;
    expR = 12'd4095; expG = 12'd4095; expB = 12'd0;
    frame(12, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(3);
    rV = 12'd100; gaV = 12'd200; gbV = 12'd202; bV = 12'd50;
    expR = 12'd100; expG = 12'd201; expB = 12'd50;

    // Valid gaps
    frame(12, 2'b10, 1'b0, 1'b1, 1'b0);
    idle(3);

    // iSOF arriving at x=2 of row 1 restarts the frame
    frame(6, 2'b11, 1'b0, 1'b0, 1'b0);
    frame(12, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Grey bypass
    frame(12, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Asynchronous reset in the middle of a line
    frame(9, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_red", 32'(oRed), 100);
    iRST_n = 1'b0;
    #1;
    chk_zero("async_reset");
    exp_q.delete();
    mArmed = 1'b0;
    @(negedge iCLK); #1;
    iDataValid = 1'b0; iSOF = 1'b0; iRST_n = 1'b1;
    for (int i = 0; i < 6; i++) send(DATA_W'(i + 1000), 1'b0);
    idle(3);
    frame(12, 2'b01, 1'b0, 1'b0, 1'b0);
    idle(5);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bayer_demosaic_2x2.md
Name: bayer_demosaic_2x2

Overview:
- Parametrised Bayer-to-RGB demosaicer. It is the successor to the fixed 12-bit camera-path converter.
- Owns its line buffer and its pixel/line counters, so it needs no external X/Y counters.
- Supports all four Bayer phases, selectable at run time, plus a raw/grey bypass mode.
- Sits between the sensor capture block and the green-screen keyer. It emits one RGB pixel per accepted RAW pixel once a full 2x2 window exists.

Parameters:
- DATA_W, 12: RAW sample and per-channel output width.
- LINE_W, 640: active pixels per line; also the line-buffer depth.
- CNT_W, 16: width of the internal X/Y counters and of oX/oY.

Ports:
- iCLK  in  1  clock.
- iRST_n  in  1  reset.
- iData  in  DATA_W  RAW sample.
- iDataValid  in  1  sample qualifier; one pixel is accepted per cycle while high.
- iSOF  in  1  start of frame; meaningful only when iDataValid=1; marks pixel (0,0).
- iPattern  in  2  colour at (row0,col0): 00 GRBG, 01 RGGB, 10 BGGR, 11 GBRG.
- iBypass  in  1  1 = grey output (R=G=B=newest sample).
- oRed  out  DATA_W.
- oGreen  out  DATA_W.
- oBlue  out  DATA_W.
- oDataValid  out  1.
- oSOF  out  1  with the first output pixel of a frame.
- oEOL  out  1  with the last output pixel of a line.
- oX  out  CNT_W  output pixel column, equal to window x-1.
- oY  out  CNT_W  output pixel row, equal to window y-1.

Behaviour:
- Reset is iRST_n, asynchronous, active-low; the clock is iCLK. Reset clears all outputs, counters, window registers and pattern/bypass latches to 0, and clears the "armed" flag.
- Arming: after reset, accepted pixels are ignored until the first iSOF&iDataValid. That cycle sets armed=1.
- Counters:
  - An accepted pixel with iSOF=1 is assigned (x=0, y=0).
  - Otherwise x=x+1. When x=LINE_W-1 the next pixel wraps to x=0 and y=y+1. y saturates at 2^CNT_W-1.
  - An iSOF arriving mid-frame restarts at (0,0) and discards the row context: the row-0 rule applies again.
- Latches: iPattern and iBypass are sampled only on the iSOF pixel and hold for the whole frame. Changes mid-frame have no effect.
- Line buffer:
  - Single-port-read/single-port-write RAM, LINE_W x DATA_W, addressed by x.
  - Each accepted pixel writes iData at address x and supplies the previous-row sample at x.
  - Two column registers hold the (x-1) samples of the current and previous row.
  - Window = P(y-1,x-1), P(y-1,x), P(y,x-1), P(y,x).
- Output condition: a window is complete when armed, x>=1 and y>=1. Rows 0 and columns 0 produce no output, so the output frame is (LINE_W-1) x (H-1).
- Colour selection:
  - Phase = {y[0]^iPattern[1], x[0]^iPattern[0]} locates the window relative to GRBG.
  - Each window contains exactly one R, one B and two G sites.
  - oRed = the R site sample. oBlue = the B site sample.
  - oGreen = (G_a+G_b) computed at DATA_W+1 bits, output bits [DATA_W:1] (truncating average). It never overflows.
- Bypass: oRed=oGreen=oBlue=P(y,x), with the same validity and latency as normal mode.
- Latency: outputs are registered. oDataValid rises exactly 2 iCLK cycles after the iDataValid cycle that completes the window.
- Stalls: cycles with iDataValid=0 freeze counters, window and pipeline advance. oDataValid=0 in the matching output slot. There is no back-pressure, because the downstream block always accepts.
- Output flags: oSOF=1 only for output (oX=0, oY=0). oEOL=1 when the window x=LINE_W-1. Both flags are 0 whenever oDataValid=0.
- Data hold: when oDataValid=0, oRed/oGreen/oBlue/oX/oY hold their last values.
- Simultaneous iSOF with the last pixel of a line: the iSOF wins, that pixel becomes (0,0) and no EOL output is generated for it.

Test Plan (bench uses LINE_W=4, DATA_W=12):
- Reset, then stream 4x3 GRBG (R=100, Gr=200, Gb=202, B=50), iSOF on the first pixel, continuous valid -> six outputs, each R=100 G=201 B=50. oSOF on the 1st output, oEOL on the 3rd and 6th. First oDataValid appears 2 cycles after pixel (1,1) is accepted.
- Same frame with iPattern=01/10/11, colours placed per pattern -> identical R/G/B for each pattern. Toggling iPattern mid-frame -> no change until the next iSOF.
- All G sites=4095, R=4095, B=0 -> oGreen=4095, showing no wrap.
- Valid gaps (pattern 1,0,0,1,...) -> same values and order as the continuous run, each oDataValid exactly 2 cycles after its completing pixel, oDataValid=0 elsewhere.
- Pixels sent before any iSOF -> no output. iSOF mid-frame at x=2 -> next output only after new (1,1). iBypass=1 -> R=G=B=the raw sample.
- Reset asserted mid-line for 1 cycle -> outputs 0 immediately (asynchronous). No output until the next iSOF, after which outputs match a clean frame.
